// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : step_sequencer
// Purpose  : Buffers 2-bit symbols in a 4-deep FIFO and steps a 2-bit state
//            machine with one symbol per enabled cycle. It reports a step
//            pulse, a state-changed pulse and a saturating step count.
//            Optional synchronous clear port: define STEP_CLR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module step_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef STEP_CLR_EN
    input  logic             clr,
`endif
    input  logic             in_valid,
    input  logic [1:0]       in_sym,
    output logic             in_ready,
    input  logic             en,
    output logic [1:0]       state,
    output logic             step,
    output logic             changed,
    output logic [CNT_W-1:0] step_cnt,
    output logic [2:0]       fifo_cnt
);

    localparam logic [1:0]       c_s00       = 2'b00;
    localparam logic [1:0]       c_s01       = 2'b01;
    localparam logic [1:0]       c_s10       = 2'b10;
    localparam logic [1:0]       c_s11       = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [2:0]       c_fifo_full = 3'd4;

    logic [1:0]       r_mem [4];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_cnt;
    logic [1:0]       r_state;
    logic             r_step;
    logic             r_changed;
    logic [CNT_W-1:0] r_step_cnt;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head;
    logic [1:0]       w_nxt;

    // Readiness depends only on the registered count, never on en.
    assign in_ready = (r_cnt != c_fifo_full);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = en && (r_cnt != 3'd0);
    assign w_head   = r_mem[r_rptr];

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            c_s00:   w_nxt = (w_head == 2'b11) ? c_s11 : c_s00;
            c_s01:   w_nxt = w_head[1] ? c_s11 : c_s01;
            default: w_nxt = w_head[1] ? c_s01 : c_s10;
        endcase
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_sym;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
            r_cnt      <= 3'd0;
            r_state    <= c_s00;
            r_step     <= 1'b0;
            r_changed  <= 1'b0;
            r_step_cnt <= '0;
        end
`ifdef STEP_CLR_EN
        else if (clr) begin
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
            r_cnt      <= 3'd0;
            r_state    <= c_s00;
            r_step     <= 1'b0;
            r_changed  <= 1'b0;
            r_step_cnt <= '0;
        end
`endif
        else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
            r_step    <= w_pop;
            r_changed <= w_pop && (w_nxt != r_state);
            if (w_pop) begin
                r_state <= w_nxt;
                if (r_step_cnt != c_cnt_max) begin
                    r_step_cnt <= r_step_cnt + 1'b1;
                end
            end
        end
    end

    assign state    = r_state;
    assign step     = r_step;
    assign changed  = r_changed;
    assign step_cnt = r_step_cnt;
    assign fifo_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_sequencer
// Purpose  : Randomized and directed bench for step_sequencer, compared every
//            cycle against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
`ifdef STEP_CLR_EN
    logic             clr;
`endif
    logic             in_valid;
    logic [1:0]       in_sym;
    logic             in_ready;
    logic             en;
    logic [1:0]       state;
    logic             step;
    logic             changed;
    logic [CNT_W-1:0] step_cnt;
    logic [2:0]       fifo_cnt;

    step_sequencer #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef STEP_CLR_EN
        .clr      (clr),
`endif
        .in_valid (in_valid),
        .in_sym   (in_sym),
        .in_ready (in_ready),
        .en       (en),
        .state    (state),
        .step     (step),
        .changed  (changed),
        .step_cnt (step_cnt),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model
    logic [1:0] q[$];
    logic [1:0] m_state;
    logic       m_step;
    logic       m_chg;
    int         m_cnt;
    int         total = 0;
    int         bad   = 0;
    logic       run   = 1'b0;

    function automatic logic [1:0] rule(input logic [1:0] s, input logic [1:0] sym);
        if (s == 2'b00) return (sym == 2'b11) ? 2'b11 : 2'b00;
        if (s == 2'b01) return sym[1] ? 2'b11 : 2'b01;
        return sym[1] ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 2'b00;
        m_step  = 1'b0;
        m_chg   = 1'b0;
        m_cnt   = 0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("state",    32'(state),    32'(m_state));
            chk("step",     32'(step),     32'(m_step));
            chk("changed",  32'(changed),  32'(m_chg));
            chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
            chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 4));
        end
    end

    task automatic do_cycle(input logic v, input logic [1:0] s, input logic e);
        logic       push;
        logic       pop;
        logic [1:0] sym;
        logic [1:0] nxt;
        in_valid = v;
        in_sym   = s;
        en       = e;
        push = v && (q.size() < 4);
        pop  = e && (q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) begin
            sym     = q.pop_front();
            nxt     = rule(m_state, sym);
            m_step  = 1'b1;
            m_chg   = (nxt != m_state);
            m_state = nxt;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_step = 1'b0;
            m_chg  = 1'b0;
        end
        if (push) q.push_back(s);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        en       = 1'b0;
        rst      = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0;
        in_sym   = 2'b00;
        en       = 1'b0;
`ifdef STEP_CLR_EN
        clr      = 1'b0;
`endif
        rst      = 1'b1;
        model_reset();
        run      = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        do_reset();
        do_cycle(1'b0, 2'b00, 1'b0);
        do_cycle(1'b0, 2'b00, 1'b1);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_cnt",   32'(step_cnt), 32'd0);

        // Symbols 11,00,10,00 with en held high
        do_cycle(1'b1, 2'b11, 1'b1);
        chk("seq_fifo_first_push", 32'(fifo_cnt), 32'd1);
        do_cycle(1'b1, 2'b00, 1'b1);
        chk("seq_s1", 32'({state, changed}), 32'({2'b11, 1'b1}));
        do_cycle(1'b1, 2'b10, 1'b1);
        chk("seq_s2", 32'({state, changed}), 32'({2'b10, 1'b1}));
        do_cycle(1'b1, 2'b00, 1'b1);
        chk("seq_s3", 32'({state, changed}), 32'({2'b01, 1'b1}));
        do_cycle(1'b0, 2'b11, 1'b1);
        chk("seq_s4", 32'({state, changed, step}), 32'({2'b01, 1'b0, 1'b1}));
        chk("seq_cnt", 32'(step_cnt), 32'd4);

        // Fill with en low; fifth symbol is refused
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 2'($urandom), 1'b0);
        chk("full_cnt",   32'(fifo_cnt), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 2'($urandom), 1'b1);
        chk("drained", 32'(fifo_cnt), 32'd0);

        // Simultaneous push/pop at depth two, across pointer wrap
        do_cycle(1'b1, 2'($urandom), 1'b0);
        do_cycle(1'b1, 2'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) begin
            do_cycle(1'b1, 2'($urandom), 1'b1);
            chk("pushpop_cnt", 32'(fifo_cnt), 32'd2);
        end

        // Async reset between edges with 3 symbols buffered
        do_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 2'($urandom), 1'b0);
        chk("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_fifo",  32'(fifo_cnt), 32'd0);
        chk("async_rst_state", 32'(state),    32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_cycle(1'b1, 2'b11, 1'b0);
        chk("first_push_after_rst", 32'(fifo_cnt), 32'd1);

`ifdef STEP_CLR_EN
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 2'b11, 1'b1);
        in_valid = 1'b1;
        en       = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        chk("clr_fifo",  32'(fifo_cnt), 32'd0);
        chk("clr_state", 32'(state),    32'd0);
        chk("clr_cnt",   32'(step_cnt), 32'd0);
`endif

        // 300+ pops: step counter must saturate
        for (int i = 0; i < 320; i++) do_cycle(1'b1, 2'($urandom), 1'b1);
        chk("sat_cnt", 32'(step_cnt), 32'd255);

        // Random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            do_cycle(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 1000; i++) begin
            do_cycle(($urandom_range(0, 2) == 0), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
